display_scan_controller: RTL
============================

Name: display_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS seven-segment digits over one shared BCD/status-to-7-segment decoder.
- Holds a shadow copy of every digit code, so a display update changes all digits in the same cycle (no tearing).
- Steps through the digits at a prescaled rate and drives a one-hot, active-low digit select to the display.
- Sits between the status/BCD sources and the single decoder instance that feeds the segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
CODE_W, 4, width of each digit code fed to the decoder
DIV, 50000, clk cycles each digit stays lit (>= 2)
DEAD_CYCLES, 4, blanking cycles between digits; used only with SCAN_DEADTIME_EN (>= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scanning active; 0 = all digits dark
load  in  1  one-cycle strobe; captures digits_in into the shadow registers
digits_in  in  NUM_DIGITS*CODE_W  digit codes; digit k is bits [k*CODE_W +: CODE_W]
code_out  out  CODE_W  code of the lit digit, to the shared decoder input
digit_sel_n  out  NUM_DIGITS  one-hot active-low select; bit k low = digit k lit
digit_idx  out  clog2(NUM_DIGITS)  index of the current digit
frame_done  out  1  one-cycle pulse when scanning wraps from the last digit to digit 0

Behaviour:
- Reset (async, while high): state IDLE, prescaler 0, digit_idx 0, shadow all 0, digit_sel_n all 1, code_out 0, frame_done 0.
- State IDLE:
  - digit_sel_n all 1, prescaler held at 0.
  - enable=1 on an edge -> next state SHOW, digit_idx 0; digit_sel_n[0]=0 from that edge.
- State SHOW:
  - Prescaler counts 0..DIV-1; tick = (prescaler == DIV-1) while in SHOW.
  - On tick: prescaler -> 0, digit_idx -> digit_idx+1.
  - Wrap: when digit_idx = NUM_DIGITS-1, tick sends digit_idx to 0 and frame_done=1 for exactly that cycle (registered, visible after the tick edge).
  - Each digit is lit for exactly DIV cycles; one frame = NUM_DIGITS*DIV cycles.
  - digit_sel_n is registered and stays one-hot-low on digit_idx for the whole state; no two digits are ever low together.
- enable=0 in any state -> IDLE on the next edge: all digits dark, prescaler 0, digit_idx 0, frame_done 0. Re-enabling restarts at digit 0.
- Load:
  - On an edge with load=1, all shadow registers take digits_in.
  - code_out = shadow[digit_idx], combinational from registers, so a new value appears on the cycle after the load edge.
  - Load is accepted in every state, including IDLE.
  - Load coinciding with a tick: both take effect; the newly lit digit shows the new shadow value.
- code_out is valid in every state; in IDLE it is shadow[0].
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SCAN_DEADTIME_EN (ghosting suppression).
- Defined:
  - Adds state DEAD. A tick in SHOW goes to DEAD instead of switching digits directly.
  - In DEAD: digit_sel_n all 1 for DEAD_CYCLES cycles; digit_idx and frame_done update on entry to DEAD.
  - Then SHOW with the new digit lit for DIV cycles; frame = NUM_DIGITS*(DIV+DEAD_CYCLES) cycles.
  - enable=0 in DEAD -> IDLE.
- Not defined: no DEAD state, DEAD_CYCLES ignored; behaviour exactly as in Behaviour.

Test Plan:
- Reset and enable: NUM_DIGITS=4, DIV=4; reset, then enable=1 -> digit_sel_n = 1110 on the first edge; 1101 after 4 cycles, then 1011, then 0111; frame_done pulses once at the wrap to 1110 (16 cycles per frame).
- Load: digits_in = 0x4321, load for one cycle -> code_out = 1, 2, 3, 4 while digits 0..3 are lit; reloading 0x8765 mid-frame changes code_out on the next cycle with no skipped digit.
- Load on a tick: pulse load exactly on a tick edge -> the next lit digit shows the new value on its first cycle.
- Enable toggle: drop enable while digit 2 is lit -> next edge digit_sel_n = 1111, digit_idx 0; re-enable -> 1110, full DIV dwell.
- Async reset mid-frame: assert reset between edges -> digit_sel_n = 1111 and code_out = 0 immediately; shadow cleared (code_out = 0 after release and re-enable).
- With SCAN_DEADTIME_EN, DEAD_CYCLES=2, DIV=4: 4 cycles lit, 2 cycles 1111, next digit lit; frame = 24 cycles; a one-hot check never sees two digits low.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// Bundle of the scan controller's control inputs and display-side outputs.
// The controller takes the slave modport; the source and display side take the master modport.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                         enable;
  logic                         load;
  logic [NUM_DIGITS*CODE_W-1:0] digits_in;
  logic [CODE_W-1:0]            code_out;
  logic [NUM_DIGITS-1:0]        digit_sel_n;
  logic [IDX_W-1:0]             digit_idx;
  logic                         frame_done;

  modport master (
    output enable, load, digits_in,
    input  code_out, digit_sel_n, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, digits_in,
    output code_out, digit_sel_n, digit_idx, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexes NUM_DIGITS seven-segment digits over one shared decoder using a shadow code bank.
// Define SCAN_DEADTIME_EN to insert DEAD_CYCLES of all-dark blanking between digits.
module display_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int CODE_W      = 4,
  parameter int DIV         = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input logic                        clk,
  input logic                        reset,
  display_scan_controller_if.slave   bus
);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DIV > DEAD_CYCLES) ? DIV : DEAD_CYCLES;
  localparam int PW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_DEAD} state_t;

  state_t                               state_q, state_d;
  logic [PW-1:0]                        presc_q, presc_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [NUM_DIGITS-1:0]                sel_n_q, sel_n_d;
  logic                                 frame_q, frame_d;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]    shadow_q, shadow_d;

  logic             tick, last;
  logic [IDX_W-1:0] nxt_idx;

  function automatic logic [NUM_DIGITS-1:0] sel_for(input logic [IDX_W-1:0] i);
    return ~(NUM_DIGITS'(1) << i);
  endfunction

  assign tick    = (presc_q == PW'(DIV - 1));
  assign last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign nxt_idx = last ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    sel_n_d  = sel_n_q;
    frame_d  = 1'b0;
    shadow_d = bus.load ? bus.digits_in : shadow_q;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      presc_d = '0;
      idx_d   = '0;
      sel_n_d = '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          presc_d = '0;
          idx_d   = '0;
          sel_n_d = sel_for('0);
        end
        ST_SHOW: begin
          if (tick) begin
            presc_d = '0;
            idx_d   = nxt_idx;
            frame_d = last;
`ifdef SCAN_DEADTIME_EN
            state_d = ST_DEAD;
            sel_n_d = '1;
`else
            sel_n_d = sel_for(nxt_idx);
`endif
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
`ifdef SCAN_DEADTIME_EN
        // Index already advanced on entry; only the select waits out the blanking.
        ST_DEAD: begin
          if (presc_q == PW'(DEAD_CYCLES - 1)) begin
            state_d = ST_SHOW;
            presc_d = '0;
            sel_n_d = sel_for(idx_q);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          idx_d   = '0;
          sel_n_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      idx_q    <= '0;
      sel_n_q  <= '1;
      frame_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sel_n_q  <= sel_n_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.code_out    = shadow_q[idx_q];
  assign bus.digit_sel_n = sel_n_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_done  = frame_q;
endmodule
